// File: rtl/npu_ahb_to_sram.sv
// npu_ahb_to_sram: AHB-Lite slave (HCLK/HRESETn, H* bus inputs; HREADYOUT/HRESP/HRDATA outputs) driving a registered-read SRAM (SRAM* port) through a one-entry write buffer
module npu_ahb_to_sram #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW-1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS
);
  logic acc, rd_acc, wr_acc, dp_wr, dp_rd, buf_pend;
  logic [AW-3:0] ap_addr, rd_addr, buf_addr;
  logic [3:0] ap_be, buf_be, be, hit;
  logic [31:0] buf_data;
  assign acc = HSEL & HREADY & (HTRANS >= 2'b10);
  assign rd_acc = acc & ~HWRITE;
  assign wr_acc = acc & HWRITE;
  assign be = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign HREADYOUT = ~(buf_pend & dp_wr & HSEL & (HTRANS >= 2'b10) & ~HWRITE);
  assign HRESP = 1'b0;
  assign SRAMCS = rd_acc | buf_pend;
  assign SRAMWEN = (rd_acc | ~buf_pend) ? 4'b0000 : buf_be;
  assign SRAMADDR = rd_acc ? HADDR[AW-1:2] : buf_addr;
  assign SRAMWDATA = buf_data;
  assign hit = (buf_pend && buf_addr == rd_addr) ? buf_be : 4'b0000;
  always_comb begin
    HRDATA = '0;
    for (int i = 0; i < 4; i++)
      HRDATA[8*i+:8] = dp_rd ? (hit[i] ? buf_data[8*i+:8] : SRAMRDATA[8*i+:8]) : 8'h00;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_wr <= 1'b0;
      dp_rd <= 1'b0;
      buf_pend <= 1'b0;
      ap_addr <= '0;
      ap_be <= '0;
      rd_addr <= '0;
      buf_addr <= '0;
      buf_be <= '0;
      buf_data <= '0;
    end else begin
      if (HREADY) begin
        dp_wr <= wr_acc;
        dp_rd <= rd_acc;
      end
      if (wr_acc) begin
        ap_addr <= HADDR[AW-1:2];
        ap_be <= be;
      end
      if (rd_acc) rd_addr <= HADDR[AW-1:2];
      if (dp_wr && HREADYOUT) begin
        buf_addr <= ap_addr;
        buf_be <= ap_be;
        buf_data <= HWDATA;
        buf_pend <= 1'b1;
      end else if (!rd_acc) begin
        buf_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_npu_ahb_to_sram.sv
// tb_npu_ahb_to_sram: table-driven and scoreboard bench for the AHB-to-SRAM bridge
module tb_npu_ahb_to_sram;
  logic clk = 1'b0, rst_n = 1'b1;
  logic hsel, hready, hwrite, hreadyout, hresp, sram_cs;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [15:0] haddr;
  logic [31:0] hwdata, hrdata, sram_rdata, sram_wdata;
  logic [13:0] sram_addr;
  logic [3:0] sram_wen;
  typedef struct {logic valid; logic wr; logic [2:0] size; logic [15:0] addr; logic [31:0] data;} op_t;
  typedef struct {logic [2:0] size; logic [15:0] addr; logic [31:0] data; logic [3:0] wen; logic [13:0] waddr;} vec_t;
  op_t q[$];
  logic [31:0] sb[$];
  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  vec_t vt [7];
  int checks = 0, errors = 0, stalls = 0, tbl_stalls = 0;
  logic st_cs;
  logic [3:0] st_wen;
  logic [13:0] st_addr;
  logic [31:0] old;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  npu_ahb_to_sram #(.AW(16)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .SRAMRDATA(sram_rdata),
    .SRAMADDR(sram_addr), .SRAMWEN(sram_wen), .SRAMWDATA(sram_wdata), .SRAMCS(sram_cs)
  );

  always @(posedge clk) begin
    sram_rdata <= (sram_cs && sram_wen == 4'h0) ? mem[sram_addr] : 32'h0;
    if (sram_cs)
      for (int i = 0; i < 4; i++)
        if (sram_wen[i]) mem[sram_addr][8*i+:8] <= sram_wdata[8*i+:8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] be_of(input logic [2:0] s, input logic [15:0] a);
    if (s == 3'd0) begin
      case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic op_t mk(input logic w, input logic [2:0] s, input logic [15:0] a, input logic [31:0] d);
    op_t o;
    o.valid = 1'b1; o.wr = w; o.size = s; o.addr = a; o.data = d;
    return o;
  endfunction

  task automatic run();
    op_t cur, prev;
    logic [3:0] b;
    int n;
    prev = '{1'b0, 1'b0, 3'd0, 16'h0, 32'h0};
    stalls = 0;
    while (q.size() > 0 || prev.valid) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{1'b0, 1'b0, 3'd0, 16'h0, 32'h0};
      hsel = cur.valid;
      htrans = cur.valid ? 2'b10 : 2'b00;
      hwrite = cur.wr;
      hsize = cur.size;
      haddr = cur.addr;
      hwdata = (prev.valid && prev.wr) ? prev.data : 32'h0;
      if (cur.valid && cur.wr) begin
        b = be_of(cur.size, cur.addr);
        for (int i = 0; i < 4; i++)
          if (b[i]) ref_mem[cur.addr[15:2]][8*i+:8] = cur.data[8*i+:8];
      end else if (cur.valid) begin
        sb.push_back(ref_mem[cur.addr[15:2]]);
      end
      @(negedge clk);
      n = 0;
      while (!hreadyout && n < 8) begin
        if (n == 0) begin st_cs = sram_cs; st_wen = sram_wen; st_addr = sram_addr; end
        stalls++;
        n++;
        @(negedge clk);
      end
      if (!hreadyout) begin
        checks++; errors++;
        $display("FAIL hreadyout_timeout actual=0 expected=1");
      end
      if (prev.valid && !prev.wr) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=%h expected=queued", hrdata);
        end else chk("rdata", hrdata, sb.pop_front());
      end
      @(posedge clk); #1;
      prev = cur;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3'd2, 16'h0010, 32'hDEADBEEF, 4'b1111, 14'h004};
    vt[1] = '{3'd0, 16'h0041, 32'h0000AA00, 4'b0010, 14'h010};
    vt[2] = '{3'd0, 16'h0043, 32'hBB000000, 4'b1000, 14'h010};
    vt[3] = '{3'd1, 16'h0032, 32'hBEEF0000, 4'b1100, 14'h00C};
    vt[4] = '{3'd1, 16'h0050, 32'h00001234, 4'b0011, 14'h014};
    vt[5] = '{3'd7, 16'h0060, 32'hCAFEF00D, 4'b1111, 14'h018};
    vt[6] = '{3'd0, 16'h0040, 32'h000000CC, 4'b0001, 14'h010};
    for (int i = 0; i < 16384; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem[8] = 32'h11223344;
    ref_mem[8] = 32'h11223344;
    hsel = 0; htrans = 2'b00; hwrite = 0; hsize = 3'd2; haddr = 16'h0; hwdata = 32'h0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_cs", sram_cs, 0);
    chk("rst_wen", sram_wen, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      q.push_back(mk(1'b1, vt[k].size, vt[k].addr, vt[k].data));
      run();
      tbl_stalls += stalls;
      @(negedge clk);
      chk("tbl_cs", sram_cs, 1);
      chk("tbl_wen", sram_wen, vt[k].wen);
      chk("tbl_addr", sram_addr, vt[k].waddr);
      chk("tbl_wdata", sram_wdata, vt[k].data);
      @(posedge clk); #1;
      q.push_back(mk(1'b0, 3'd2, {vt[k].addr[15:2], 2'b00}, 32'h0));
      run();
      tbl_stalls += stalls;
    end
    chk("tbl_no_stall", tbl_stalls, 0);

    q.push_back(mk(1'b1, 3'd0, 16'h0021, 32'h0000AA00));
    q.push_back(mk(1'b0, 3'd2, 16'h0020, 32'h0));
    run();
    chk("merge_no_stall", stalls, 0);
    repeat (2) @(posedge clk);
    #1 chk("merge_commit", mem[8], 32'h1122AA44);

    q.push_back(mk(1'b1, 3'd2, 16'h0100, 32'h11111111));
    q.push_back(mk(1'b1, 3'd2, 16'h0104, 32'h22222222));
    q.push_back(mk(1'b0, 3'd2, 16'h0104, 32'h0));
    run();
    chk("haz_stall_cycles", stalls, 1);
    chk("haz_commit_cs", st_cs, 1);
    chk("haz_commit_wen", st_wen, 4'hF);
    chk("haz_commit_addr", st_addr, 14'h040);
    repeat (3) @(posedge clk);
    #1 chk("haz_w1_mem", mem[14'h040], 32'h11111111);
    chk("haz_w2_mem", mem[14'h041], 32'h22222222);

    q.push_back(mk(1'b1, 3'd2, 16'h0200, 32'hA5A5A5A5));
    q.push_back(mk(1'b0, 3'd2, 16'h0200, 32'h0));
    q.push_back(mk(1'b0, 3'd2, 16'h0200, 32'h0));
    q.push_back(mk(1'b0, 3'd2, 16'h0204, 32'h0));
    run();
    chk("rdrun_no_stall", stalls, 0);
    repeat (2) @(posedge clk);
    #1 chk("rdrun_commit", mem[14'h080], 32'hA5A5A5A5);

    old = ref_mem[14'h0C0];
    q.push_back(mk(1'b1, 3'd2, 16'h0300, 32'h77777777));
    run();
    chk("pre_rst_pend_cs", sram_cs, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", sram_cs, 0);
    chk("mid_rst_hrdata", hrdata, 0);
    chk("mid_rst_wen", sram_wen, 0);
    chk("mid_rst_hreadyout", hreadyout, 1);
    ref_mem[14'h0C0] = old;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("rst_discard_mem", mem[14'h0C0], 32'h0);
    q.push_back(mk(1'b0, 3'd2, 16'h0300, 32'h0));
    run();

    hsel = 0; htrans = 2'b10; hwrite = 0; hsize = 3'd2; haddr = 16'h0010;
    @(negedge clk);
    chk("nosel_cs", sram_cs, 0);
    chk("nosel_hreadyout", hreadyout, 1);
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    chk("nosel_hrdata", hrdata, 0);
    chk("hresp_const", hresp, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
